// File: rtl/issue_scoreboard.sv
// Issue scoreboard: tracks registers with writes in flight, stalls RAW/WAW
// hazards at the issue point, counts hazard stalls and supports a drain
// handshake that holds off issue until every pending write has completed.
//
// Optional feature macro: SCB_WB_BYPASS_EN
//   defined   -> hazard checks ignore the register being written back this
//                cycle, so a dependent instruction can issue alongside it.
//   undefined -> hazard checks use the registered busy map only.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-high reset
//   id_valid     decoded instruction present at the issue point
//   id_instr     {opcode, rd, rs1, rs2}, 4 bits each
//   issue_ready  combinational; instruction issues when id_valid && issue_ready
//   wb_valid     writeback of wb_dest completes this cycle
//   wb_dest      register index being written back
//   drain_req    request to empty all pending writes
//   drain_done   registered; drained and holding
//   busy_map     registered; bit n set while register n has a write in flight
//   stall_count  registered saturating hazard-stall counter
//   hazard_err   registered, sticky; writeback to a register not marked busy
module issue_scoreboard #(
  parameter int unsigned STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [15:0]            id_instr,
  output logic                   issue_ready,
  input  logic                   wb_valid,
  input  logic [3:0]             wb_dest,
  input  logic                   drain_req,
  output logic                   drain_done,
  output logic [15:0]            busy_map,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   hazard_err
);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpSub  = 4'b0010;
  localparam logic [3:0] OpLoad = 4'b0011;

  state_e                 state_q, state_d;
  logic [15:0]            busy_q, busy_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;

  logic [3:0]  opcode, rd, rs1, rs2;
  logic        reads_src, writes_rd;
  logic [15:0] wb_mask, hz_map;
  logic        raw_hz, waw_hz, fire;

  assign opcode = id_instr[15:12];
  assign rd     = id_instr[11:8];
  assign rs1    = id_instr[7:4];
  assign rs2    = id_instr[3:0];

  assign reads_src = (opcode == OpAdd) || (opcode == OpSub);
  assign writes_rd = reads_src || (opcode == OpLoad);

  assign wb_mask = wb_valid ? (16'h0001 << wb_dest) : 16'h0000;

`ifdef SCB_WB_BYPASS_EN
  assign hz_map = busy_q & ~wb_mask;
`else
  assign hz_map = busy_q;
`endif

  assign raw_hz = reads_src && (hz_map[rs1] || hz_map[rs2]);
  assign waw_hz = writes_rd && hz_map[rd];
  assign fire   = id_valid && issue_ready;

  // Output logic (combinational issue gate).
  always_comb begin
    issue_ready = (state_q == StRun) && !raw_hz && !waw_hz;
  end

  // Datapath next state: clear on writeback first so a same-cycle issue to the
  // same register leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (wb_valid) begin
      if (busy_q[wb_dest]) begin
        busy_d = busy_q & ~wb_mask;
      end else begin
        err_d = 1'b1;
      end
    end
    if (fire && writes_rd) begin
      busy_d[rd] = 1'b1;
    end

    stall_d = stall_q;
    if ((state_q == StRun) && id_valid && !issue_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  // FSM next state; drain completion looks at the map after this cycle's writeback.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (drain_req) state_d = StDrain;
      StDrain: begin
        if (!drain_req) begin
          state_d = StRun;
        end else if (busy_d == 16'h0000) begin
          state_d = StDone;
        end
      end
      StDone:  if (!drain_req) state_d = StRun;
      default: state_d = StRun;
    endcase
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      busy_q  <= 16'h0000;
      stall_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign drain_done  = done_q;
  assign busy_map    = busy_q;
  assign stall_count = stall_q;
  assign hazard_err  = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: a cycle-level behavioural model
// checked against the DUT on every cycle, plus directed scenarios with literal
// expectations.
module tb_issue_scoreboard;

  localparam int unsigned W = 8;
  localparam int CntMax = (1 << W) - 1;

`ifdef SCB_WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif
  // Stall cycles accumulated before the drain scenario (dependent SUB + WAW LOAD).
  localparam int C1 = Byp ? 5 : 6;

  logic           clk = 1'b0;
  logic           reset;
  logic           id_valid;
  logic [15:0]    id_instr;
  logic           issue_ready;
  logic           wb_valid;
  logic [3:0]     wb_dest;
  logic           drain_req;
  logic           drain_done;
  logic [15:0]    busy_map;
  logic [W-1:0]   stall_count;
  logic           hazard_err;

  int n_cmp = 0;
  int n_bad = 0;

  issue_scoreboard #(.STALL_CNT_W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .drain_req   (drain_req),
    .drain_done  (drain_done),
    .busy_map    (busy_map),
    .stall_count (stall_count),
    .hazard_err  (hazard_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int rd, input int r1, input int r2);
    return {4'(op), 4'(rd), 4'(r1), 4'(r2)};
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 = run, 1 = drain, 2 = done
  bit m_busy [16];
  int m_mode, m_cnt;
  bit m_err, m_done;
  bit n_busy [16];
  int n_mode, n_cnt;
  bit n_err, n_done;

  task automatic m_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_mode = 0; m_cnt = 0; m_err = 1'b0; m_done = 1'b0;
  endtask

  function automatic logic [15:0] m_map();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit m_ready();
    int op, d, a, b;
    bit view [16];
    op = int'(id_instr[15:12]); d = int'(id_instr[11:8]);
    a = int'(id_instr[7:4]);    b = int'(id_instr[3:0]);
    if (m_mode != 0) return 1'b0;
    view = m_busy;
    if (Byp && wb_valid) view[wb_dest] = 1'b0;
    if ((op == 1 || op == 2) && (view[a] || view[b])) return 1'b0;
    if ((op >= 1 && op <= 3) && view[d]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_next();
    bit rdy, any;
    int op;
    rdy = m_ready();
    op = int'(id_instr[15:12]);
    n_busy = m_busy; n_err = m_err; n_cnt = m_cnt;
    if (wb_valid) begin
      if (m_busy[wb_dest]) n_busy[wb_dest] = 1'b0;
      else n_err = 1'b1;
    end
    if (id_valid && rdy && op >= 1 && op <= 3) n_busy[id_instr[11:8]] = 1'b1;
    if (m_mode == 0 && id_valid && !rdy && m_cnt < CntMax) n_cnt = m_cnt + 1;
    any = 1'b0;
    foreach (n_busy[i]) any |= n_busy[i];
    case (m_mode)
      0: n_mode = drain_req ? 1 : 0;
      1: n_mode = !drain_req ? 0 : (any ? 1 : 2);
      default: n_mode = drain_req ? 2 : 0;
    endcase
    n_done = (n_mode == 2);
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      #2;
      if (reset) m_reset();
      chk("m_issue_ready", 32'(issue_ready), 32'(m_ready()));
      chk("m_busy_map", 32'(busy_map), 32'(m_map()));
      chk("m_stall_count", 32'(stall_count), 32'(m_cnt));
      chk("m_hazard_err", 32'(hazard_err), 32'(m_err));
      chk("m_drain_done", 32'(drain_done), 32'(m_done));
      m_next();
      @(posedge clk);
      if (reset) m_reset();
      else begin
        m_busy = n_busy; m_mode = n_mode; m_cnt = n_cnt; m_err = n_err; m_done = n_done;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input bit v, input logic [15:0] ins, input bit wv,
                     input logic [3:0] wd, input bit dr);
    @(negedge clk);
    id_valid = v; id_instr = ins; wb_valid = wv; wb_dest = wd; drain_req = dr;
    #3;
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_instr = '0; wb_valid = 1'b0; wb_dest = '0;
    drain_req = 1'b0;
    cyc(0, 16'h0, 0, 0, 0);
    cyc(0, 16'h0, 0, 0, 0);
    reset = 1'b0;
    chk("rst_busy", 32'(busy_map), 0);
    chk("rst_cnt", 32'(stall_count), 0);
    chk("rst_err", 32'(hazard_err), 0);
    chk("rst_done", 32'(drain_done), 0);

    // RAW: ADD r1,r2,r3 then dependent SUB r4,r1,r2
    cyc(1, mk(1, 1, 2, 3), 0, 0, 0);
    chk("add_ready", 32'(issue_ready), 1);
    cyc(1, mk(2, 4, 1, 2), 0, 0, 0);
    chk("raw_stall", 32'(issue_ready), 0);
    chk("raw_busy", 32'(busy_map), 32'h0002);
    cyc(1, mk(2, 4, 1, 2), 0, 0, 0);
    cyc(1, mk(2, 4, 1, 2), 0, 0, 0);
    cyc(1, mk(2, 4, 1, 2), 1, 1, 0);
    chk("raw_cnt", 32'(stall_count), 3);
    chk("wb_bypass_ready", 32'(issue_ready), 32'(Byp));
`ifndef SCB_WB_BYPASS_EN
    cyc(1, mk(2, 4, 1, 2), 0, 0, 0);
    chk("raw_release", 32'(issue_ready), 1);
`endif
    cyc(0, 16'h0, 0, 0, 0);
    chk("sub_busy", 32'(busy_map), 32'h0010);
    chk("sub_cnt", 32'(stall_count), Byp ? 3 : 4);
    cyc(0, 16'h0, 1, 4, 0);

    // WAW: LOAD r5 then LOAD r5 again
    cyc(1, mk(3, 5, 0, 9), 0, 0, 0);
    chk("load_ready", 32'(issue_ready), 1);
    cyc(1, mk(3, 5, 0, 3), 0, 0, 0);
    chk("waw_stall", 32'(issue_ready), 0);
    cyc(1, mk(3, 5, 0, 3), 0, 0, 0);
    cyc(0, 16'h0, 1, 5, 0);
    cyc(1, mk(3, 5, 0, 3), 0, 0, 0);
    chk("waw_release", 32'(issue_ready), 1);
    cyc(1, mk(3, 1, 0, 0), 0, 0, 0);
    chk("waw_busy", 32'(busy_map), 32'h0020);

    // Drain with r1, r5 pending
    cyc(0, 16'h0, 0, 0, 1);
    chk("drain_busy", 32'(busy_map), 32'h0022);
    cyc(1, mk(1, 6, 7, 8), 0, 0, 1);
    chk("drain_block", 32'(issue_ready), 0);
    chk("drain_cnt", 32'(stall_count), C1);
    cyc(1, mk(1, 6, 7, 8), 1, 1, 1);
    cyc(1, mk(1, 6, 7, 8), 1, 5, 1);
    chk("drain_not_done", 32'(drain_done), 0);
    cyc(1, mk(1, 6, 7, 8), 0, 0, 1);
    chk("drain_done", 32'(drain_done), 1);
    chk("done_block", 32'(issue_ready), 0);
    chk("done_cnt", 32'(stall_count), C1);
    cyc(0, 16'h0, 0, 0, 0);
    cyc(1, mk(1, 6, 7, 8), 0, 0, 0);
    chk("resume_done", 32'(drain_done), 0);
    chk("resume_ready", 32'(issue_ready), 1);
    cyc(0, 16'h0, 1, 6, 0);

    // Drain with nothing pending reaches done one cycle after entry
    cyc(0, 16'h0, 0, 0, 1);
    cyc(0, 16'h0, 0, 0, 1);
    chk("empty_drain_wait", 32'(drain_done), 0);
    cyc(0, 16'h0, 0, 0, 0);
    chk("empty_drain_done", 32'(drain_done), 1);
    cyc(0, 16'h0, 0, 0, 0);
    chk("empty_drain_exit", 32'(drain_done), 0);

    // Drain aborted while a write is pending
    cyc(1, mk(3, 2, 0, 0), 0, 0, 0);
    cyc(0, 16'h0, 0, 0, 1);
    cyc(0, 16'h0, 0, 0, 0);
    cyc(1, mk(1, 3, 4, 5), 0, 0, 0);
    chk("abort_ready", 32'(issue_ready), 1);
    cyc(0, 16'h0, 1, 2, 0);
    cyc(0, 16'h0, 1, 3, 0);

    // Spurious writeback and stall-counter saturation
    cyc(0, 16'h0, 1, 7, 0);
    cyc(0, 16'h0, 0, 0, 0);
    chk("spurious_err", 32'(hazard_err), 1);
    chk("spurious_busy", 32'(busy_map), 0);
    cyc(1, mk(3, 9, 0, 0), 0, 0, 0);
    repeat (300) cyc(1, mk(1, 10, 9, 9), 0, 0, 0);
    chk("sat_cnt", 32'(stall_count), 255);
    chk("err_sticky", 32'(hazard_err), 1);
    cyc(0, 16'h0, 1, 9, 0);

    // Asynchronous reset in the middle of a drain
    for (int r = 4; r < 8; r++) cyc(1, mk(3, r, 0, 0), 0, 0, 0);
    cyc(0, 16'h0, 0, 0, 1);
    chk("pre_rst_busy", 32'(busy_map), 32'h00F0);
    cyc(1, mk(1, 8, 9, 10), 0, 0, 1);
    chk("pre_rst_block", 32'(issue_ready), 0);
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_map), 0);
    chk("arst_cnt", 32'(stall_count), 0);
    chk("arst_err", 32'(hazard_err), 0);
    chk("arst_done", 32'(drain_done), 0);
    chk("arst_ready", 32'(issue_ready), 1);
    cyc(0, 16'h0, 0, 0, 0);
    reset = 1'b0;
    cyc(0, 16'h0, 1, 4, 0);
    cyc(0, 16'h0, 0, 0, 0);
    chk("post_rst_wb_err", 32'(hazard_err), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 Parameter STALL_CNT_W, default 8, width of the saturating stall counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 id_valid  in  1  decoded instruction present at issue point.
REQ-005 id_instr  in  16  instruction {opcode[15:12], rd[11:8], rs1[7:4], rs2[3:0]}.
REQ-006 issue_ready  out  1  combinational; instruction issues in a cycle with id_valid=1 and issue_ready=1 ("issue fire").
REQ-007 wb_valid  in  1  writeback of wb_dest completes this cycle.
REQ-008 wb_dest  in  4  register index being written back.
REQ-009 drain_req  in  1  request to empty all pending writes.
REQ-010 drain_done  out  1  registered; pipeline drained and held.
REQ-011 busy_map  out  16  registered; bit n=1 means register n has a write in flight.
REQ-012 stall_count  out  STALL_CNT_W  registered saturating hazard-stall counter.
REQ-013 hazard_err  out  1  registered, sticky; writeback to a register not marked busy.

Function
REQ-014 Opcodes: ADD=4'b0001, SUB=4'b0010 (read rs1, rs2, write rd); LOAD=4'b0011 (write rd, no register reads); all others write nothing and read nothing.
REQ-015 RAW hazard: ADD/SUB whose rs1 or rs2 bit is set in busy_map; WAW hazard: ADD/SUB/LOAD whose rd bit is set.
REQ-016 issue_ready = (state==RUN) and no RAW/WAW hazard; non-writing opcodes are never hazard-stalled in RUN.
REQ-017 On issue fire of ADD/SUB/LOAD, busy_map[rd] is set on the next edge.
REQ-018 On wb_valid, busy_map[wb_dest] is cleared on the next edge.
REQ-019 Simultaneous issue fire writing rd and wb_valid with wb_dest==rd: set wins, bit stays 1.
REQ-020 wb_valid with busy_map[wb_dest]==0 sets hazard_err to 1 until reset; busy_map unchanged.
REQ-021 stall_count increments by 1 in each cycle with state==RUN, id_valid=1, issue_ready=0; saturates at all-ones.
REQ-022 FSM states RUN, DRAIN, DONE; RUN->DRAIN when drain_req=1.
REQ-023 DRAIN: issue_ready=0; ->DONE when busy_map==0 (evaluated with this cycle's writeback applied); ->RUN if drain_req=0 first.
REQ-024 DONE: issue_ready=0, drain_done=1; ->RUN when drain_req=0; drain_done=0 in all other states.
REQ-025 Entering DRAIN with busy_map already 0 reaches DONE one cycle later.
REQ-026 Stalls in DRAIN/DONE do not increment stall_count.

Reset
REQ-027 reset asserted: state=RUN, busy_map=0, stall_count=0, hazard_err=0, drain_done=0, immediately, independent of clk.
REQ-028 Reset mid-drain discards all pending-write tracking; in-flight writebacks arriving after reset set hazard_err.

Configuration
REQ-029 Macro SCB_WB_BYPASS_EN: defined -> hazard checks use busy_map with the current-cycle wb_dest bit masked off (writeback and dependent issue in the same cycle); undefined -> hazard checks use registered busy_map only, dependent issues one cycle after writeback.

Verification
REQ-030 ADD r1,r2,r3 issues; next cycle SUB r4,r1,r2 presented -> issue_ready=0, busy_map=16'h0002, stall_count increments each cycle until wb_dest=1.
REQ-031 busy_map[1]=1, wb_valid=1 wb_dest=1 with dependent SUB r4,r1,r2 presented same cycle -> issue_ready=1 with SCB_WB_BYPASS_EN, 0 without.
REQ-032 LOAD r5,#9 issued then LOAD r5,#3 presented -> WAW stall until wb_dest=5; then issue, busy_map[5]=1 after.
REQ-033 busy_map=16'h0022, drain_req=1 -> issue_ready=0; writebacks to 1 and 5 -> drain_done=1 next cycle; drain_req=0 -> RUN.
REQ-034 wb_valid wb_dest=7 with busy_map=0 -> hazard_err=1 persisting; 300 forced stall cycles -> stall_count=255 (default width).
REQ-035 reset asserted asynchronously in DRAIN with busy_map=16'h00F0 -> all outputs zero before next clk edge, state RUN.
